multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Sequencing controller for the multi-cycle variant of the RISC-V core. The core shares one memory for instructions and data and reuses one ALU for PC increment, address generation, branch compare and arithmetic. This block steps each instruction through fetch, decode, execute, memory and writeback states. It drives every mux select and write enable in the shared datapath from the opcode, funct fields and ALU flags (ZF, SF).

## Interface
Parameters: none. All encodings are fixed constants in the shared package.

Ports (direction, width, meaning):
- clk — in, 1 — rising-edge clock, the single clock domain.
- areset — in, 1 — synchronous, active-high reset. Sampled on the rising edge of clk.
- op — in, 7 — Instr[6:0].
- funct3 — in, 3 — Instr[14:12].
- funct7b5 — in, 1 — Instr[30].
- ZF — in, 1 — ALU zero flag, valid in BRANCH.
- SF — in, 1 — ALU sign flag, valid in BRANCH.
- PCWrite — out, 1 — PC register enable.
- AdrSrc — out, 1 — memory address select: 0 = PC, 1 = ALUOut.
- MemWrite — out, 1 — memory write enable.
- IRWrite — out, 1 — instruction register and OldPC enable.
- ResultSrc — out, 2 — result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA — out, 2 — ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register.
- ALUSrcB — out, 2 — ALU B select: 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- ALUControl — out, 3 — 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
- ImmSrc — out, 2 — 00 I, 01 S, 10 B, 11 J. Combinational from op only.
- RegWrite — out, 1 — register file write enable.
- instr_done — out, 1 — one-cycle pulse in the final state of each instruction.

## Operation
States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL.

Outputs are Moore per state, except PCWrite in BRANCH. Any signal not listed is 0 and ALUOp = 00.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, PCWrite=1 → DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. This computes the branch target into ALUOut. Next state by op:
  - 0000011 (lw) or 0100011 (sw) → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 → BRANCH.
  - 1101111 → JAL.
  - Any other op → FETCH as a NOP, with instr_done=1.
- MEMADR: ALUSrcA=10, ALUSrcB=01 → MEMREAD if lw, MEMWRITE if sw.
- MEMREAD: AdrSrc=1, ResultSrc=00 → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1 → FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, instr_done=1 → FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1 → FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, instr_done=1 → FETCH.
  - PCWrite = taken, evaluated combinationally from ZF and SF.
  - funct3 000 (beq): taken = ZF.
  - funct3 001 (bne): taken = !ZF.
  - funct3 100 (blt): taken = SF.
  - Any other funct3: not taken.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1 → ALUWB. ALUWB writes OldPC+4 into rd.

ALU decode, keyed on ALUOp:
- 00 → add.
- 01 → sub.
- 10 → decode funct3:
  - 000: sub if op[5] & funct7b5, else add.
  - 010: slt.
  - 100: xor.
  - 110: or.
  - 111: and.
  - 001: sll.
  - 101: srl.
  - 011: add.

## Timing
- Reset:
  - areset high at a rising edge → state = FETCH on that edge.
  - While areset is high, PCWrite, IRWrite, MemWrite, RegWrite and instr_done are forced to 0.
  - Reset asserted mid-instruction abandons it; no write enable fires in that cycle.
- First fetch happens in the first cycle after areset is seen low.
- Latency in cycles, FETCH through final state:
  - lw: 5.
  - sw: 4.
  - R-type and I-type: 4.
  - jal: 4.
  - branch: 3.
  - unknown op: 2.
- State register updates only on the rising edge of clk. All outputs are combinational from state, op, funct3, funct7b5, ZF and SF.
- ZF and SF are consumed only in BRANCH, in the same cycle the ALU produces them.
- There is no illegal-state lockup: any unencoded state value → FETCH on the next edge.

## Structure
- Shared package riscv_ctrl_pkg holds:
  - opcode constants.
  - the state encoding (4-bit).
  - ALUOp, ALUControl, ImmSrc, ResultSrc, ALUSrcA and ALUSrcB codes.
- The datapath and testbench import the same package.
- One sub-module, alu_decoder (ALUOp, funct3, funct7b5, op[5] → ALUControl). It is purely combinational.
- The FSM and branch-condition logic live in multicycle_control_unit.

## Test plan
- Reset mid-instruction:
  - Stimulus: areset held 2 cycles during MEMADR of a lw.
  - Required: all write enables 0 in the reset cycles; state FETCH with IRWrite=1 on the first cycle after release.
- lw (op 0000011):
  - Required: visits FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - RegWrite=1 with ResultSrc=01 only in cycle 5; instr_done pulses once.
- sw (op 0100011):
  - Required: MemWrite=1 exactly in cycle 4 with AdrSrc=1, and RegWrite stays 0 throughout.
- R-type:
  - funct3=000, funct7b5=1 → ALUControl=001 in EXECR.
  - I-type with funct3=000, funct7b5=1 → ALUControl=000 (addi, not sub).
- Branches:
  - beq with ZF=1 → PCWrite=1 in BRANCH.
  - bne with ZF=1 → PCWrite=0.
  - blt with SF=1 → PCWrite=1.
  - funct3=010 → PCWrite=0.
- jal (op 1101111) and unknown op:
  - jal: FETCH, DECODE, JAL with PCWrite=1, then ALUWB with RegWrite=1.
  - op=0000000: returns to FETCH after DECODE, with no write enable asserted in DECODE.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
// Shared encodings for the multi-cycle RISC-V core: opcodes, funct3 branch
// codes, controller state encoding and every datapath select code that the
// controller drives. The datapath, the controller and the testbench all
// import this package so the encodings live in exactly one place.
package riscv_ctrl_pkg;

    // Major opcodes (Instr[6:0]) recognised by the controller
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Branch funct3 codes
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;

    // Controller states, 4-bit encoding; values 11..15 are unused
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    // ALUOp: what the controller asks of the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUControl operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    // Immediate format selects
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Result mux selects
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU operand A selects
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B selects
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Immediate format is a pure function of the opcode; anything that is
    // not S, B or J falls back to the I format.
    function automatic logic [1:0] imm_src_for(input logic [6:0] op);
        logic [1:0] imm;
        imm = IMM_I;
        case (op)
            OP_STORE:  imm = IMM_S;
            OP_BRANCH: imm = IMM_B;
            OP_JAL:    imm = IMM_J;
            default:   imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder
// Purely combinational translation of ALUOp plus the instruction's funct
// fields into the 3-bit ALUControl operation code.
// Ports:
//   alu_op      in  2  operation class requested by the controller
//   funct3      in  3  Instr[14:12]
//   funct7b5    in  1  Instr[30]
//   op5         in  1  Instr[5], distinguishes R-type from I-type
//   alu_control out 3  ALU operation code
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    // ALUOp 00/01 are fixed add/sub for address, PC and compare work.
    // ALUOp 10 decodes funct3; subtract needs both op[5] and funct7b5 so
    // that addi with a set Instr[30] still adds.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_ADD;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Sequencing FSM for the multi-cycle RISC-V core. Steps each instruction
// through fetch/decode/execute/memory/writeback and drives every select and
// write enable of the shared datapath.
// Ports:
//   clk, areset         clock and synchronous active-high reset
//   op, funct3, funct7b5  instruction fields from the instruction register
//   ZF, SF              ALU flags, consumed only in BRANCH
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ALUControl, ImmSrc, RegWrite  datapath controls
//   instr_done          one-cycle pulse in each instruction's final state
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       areset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       ZF,
    input  logic       SF,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       instr_done
);

    state_t     state;
    state_t     next_state;
    logic [1:0] alu_op;
    logic       branch_taken;
    logic       pc_write_raw;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       done_raw;

    // State register; reset parks the machine in FETCH
    always_ff @(posedge clk) begin
        if (areset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Branch condition from the flags of the rs1 - rs2 compare
    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            F3_BEQ:  branch_taken = ZF;
            F3_BNE:  branch_taken = ~ZF;
            F3_BLT:  branch_taken = SF;
            default: branch_taken = 1'b0;
        endcase
    end

    // Next-state and Moore outputs; PCWrite in BRANCH is the one Mealy term.
    // Unencoded state values fall into the default arm and return to FETCH.
    always_comb begin
        next_state    = S_FETCH;
        pc_write_raw  = 1'b0;
        AdrSrc        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        reg_write_raw = 1'b0;
        done_raw      = 1'b0;
        case (state)
            S_FETCH: begin
                AdrSrc       = 1'b0;
                ir_write_raw = 1'b1;
                ALUSrcA      = SRCA_PC;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURESULT;
                pc_write_raw = 1'b1;
                next_state   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_ADD;
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECR;
                    OP_ITYPE:          next_state = S_EXECI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    default: begin
                        next_state = S_FETCH;
                        done_raw   = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                next_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                ResultSrc  = RES_ALUOUT;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc     = RES_DATA;
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
                next_state    = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
                done_raw      = 1'b1;
                next_state    = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc     = RES_ALUOUT;
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
                next_state    = S_FETCH;
            end
            S_BRANCH: begin
                // ALUOut already holds the target computed in DECODE
                ALUSrcA      = SRCA_RS1;
                ALUSrcB      = SRCB_RS2;
                alu_op       = ALUOP_SUB;
                ResultSrc    = RES_ALUOUT;
                pc_write_raw = branch_taken;
                done_raw     = 1'b1;
                next_state   = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while OldPC+4 is formed for rd
                ALUSrcA      = SRCA_OLDPC;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALUOUT;
                pc_write_raw = 1'b1;
                next_state   = S_ALUWB;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    // Reset suppresses every write enable so an abandoned instruction
    // cannot commit anything in the reset cycle.
    assign PCWrite    = pc_write_raw  & ~areset;
    assign MemWrite   = mem_write_raw & ~areset;
    assign IRWrite    = ir_write_raw  & ~areset;
    assign RegWrite   = reg_write_raw & ~areset;
    assign instr_done = done_raw      & ~areset;

    assign ImmSrc = imm_src_for(op);

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit
// Self-checking bench: every cycle of every instruction is compared against
// a behavioural model that describes what each instruction class must do
// on each of its cycles. Inputs change on the falling edge, outputs are
// sampled 1 time unit later, well away from the rising edge.
module tb_multicycle_control_unit;
    import riscv_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       areset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       ZF;
    logic       SF;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       instr_done;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic [1:0] res;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [2:0] aluc;
        logic [1:0] imm;
        logic       regw;
        logic       done;
    } ctl_t;

    localparam logic [6:0] M_LW  = 7'b0000011;
    localparam logic [6:0] M_SW  = 7'b0100011;
    localparam logic [6:0] M_R   = 7'b0110011;
    localparam logic [6:0] M_I   = 7'b0010011;
    localparam logic [6:0] M_B   = 7'b1100011;
    localparam logic [6:0] M_JAL = 7'b1101111;

    multicycle_control_unit dut (
        .clk        (clk),
        .areset     (areset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .ZF         (ZF),
        .SF         (SF),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    function automatic ctl_t observed();
        ctl_t c;
        c.pcw  = PCWrite;
        c.adr  = AdrSrc;
        c.memw = MemWrite;
        c.irw  = IRWrite;
        c.res  = ResultSrc;
        c.srca = ALUSrcA;
        c.srcb = ALUSrcB;
        c.aluc = ALUControl;
        c.imm  = ImmSrc;
        c.regw = RegWrite;
        c.done = instr_done;
        return c;
    endfunction

    // Total cycles from fetch to the final cycle of each instruction class
    function automatic int latency(input logic [6:0] o);
        if (o == M_LW) return 5;
        if (o == M_SW || o == M_R || o == M_I || o == M_JAL) return 4;
        if (o == M_B) return 3;
        return 2;
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == M_SW) return 2'b01;
        if (o == M_B) return 2'b10;
        if (o == M_JAL) return 2'b11;
        return 2'b00;
    endfunction

    // Arithmetic operation named by funct3 for R/I instructions
    function automatic logic [2:0] arith_op(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (o == M_R && f7) ? 3'b001 : 3'b000;
            3'b001:  return 3'b110;
            3'b010:  return 3'b101;
            3'b100:  return 3'b100;
            3'b101:  return 3'b111;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic taken(input logic [2:0] f3, input logic zf, input logic sf);
        if (f3 == 3'b000) return zf;
        if (f3 == 3'b001) return !zf;
        if (f3 == 3'b100) return sf;
        return 1'b0;
    endfunction

    // Expected controls for cycle cyc (1 = fetch) of an instruction
    function automatic ctl_t expect_ctl(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                        input logic zf, input logic sf, input int cyc);
        ctl_t e;
        int n;
        e = '0;
        e.imm = imm_of(o);
        n = latency(o);
        if (cyc == 1) begin
            e.pcw = 1'b1; e.irw = 1'b1; e.srcb = 2'b10; e.res = 2'b10;
        end else if (cyc == 2) begin
            e.srca = 2'b01; e.srcb = 2'b01; e.done = (n == 2);
        end else if (cyc == n) begin
            // final cycle: the commit step of each class
            if (o == M_LW) begin
                e.res = 2'b01; e.regw = 1'b1;
            end else if (o == M_SW) begin
                e.adr = 1'b1; e.memw = 1'b1;
            end else if (o == M_B) begin
                e.srca = 2'b10; e.aluc = 3'b001; e.pcw = taken(f3, zf, sf);
            end else begin
                e.regw = 1'b1;
            end
            e.done = 1'b1;
        end else if (cyc == 3) begin
            if (o == M_LW || o == M_SW) begin
                e.srca = 2'b10; e.srcb = 2'b01;
            end else if (o == M_R) begin
                e.srca = 2'b10; e.aluc = arith_op(o, f3, f7);
            end else if (o == M_I) begin
                e.srca = 2'b10; e.srcb = 2'b01; e.aluc = arith_op(o, f3, f7);
            end else if (o == M_JAL) begin
                e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1'b1;
            end
        end else begin
            // lw cycle 4: data read from the computed address
            e.adr = 1'b1;
        end
        return e;
    endfunction

    function automatic ctl_t masked(input ctl_t c);
        ctl_t m;
        m = c;
        m.pcw = 1'b0; m.memw = 1'b0; m.irw = 1'b0; m.regw = 1'b0; m.done = 1'b0;
        return m;
    endfunction

    // Runs one full instruction; zfv/sfv < 0 means random flag per cycle
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int zfv, input int sfv, input string tag);
        ctl_t exp, got;
        int n, done_count;
        n = latency(o);
        done_count = 0;
        for (int cyc = 1; cyc <= n; cyc++) begin
            @(negedge clk);
            op = o; funct3 = f3; funct7b5 = f7;
            ZF = (zfv < 0) ? 1'($urandom_range(0, 1)) : 1'(zfv);
            SF = (sfv < 0) ? 1'($urandom_range(0, 1)) : 1'(sfv);
            #1;
            exp = expect_ctl(o, f3, f7, ZF, SF, cyc);
            got = observed();
            if (got.done) done_count++;
            checks++;
            if (got !== exp)
                $display("[TB] FAIL %s cycle %0d: controls %h, required %h", tag, cyc, got, exp);
            else
                passes++;
        end
        checks++;
        if (done_count != 1)
            $display("[TB] FAIL %s done_pulses: saw %0d, required 1", tag, done_count);
        else
            passes++;
    endtask

    task automatic test_reset();
        ctl_t exp, got;
        areset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; ZF = 1'b0; SF = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            exp = masked(expect_ctl(7'b0, 3'b0, 1'b0, 1'b0, 1'b0, 1));
            got = observed();
            checks++;
            if (got !== exp) $display("[TB] FAIL reset_hold: controls %h, required %h", got, exp);
            else passes++;
        end
        @(posedge clk); #1 areset = 1'b0;
        // start a lw and abort it in MEMADR
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            op = M_LW; funct3 = 3'b010; funct7b5 = 1'b0;
            ZF = 1'($urandom_range(0, 1)); SF = 1'($urandom_range(0, 1));
            if (cyc == 3) areset = 1'b1;
            #1;
            exp = expect_ctl(M_LW, 3'b010, 1'b0, ZF, SF, cyc);
            if (cyc == 3) exp = masked(exp);
            got = observed();
            checks++;
            if (got !== exp) $display("[TB] FAIL reset_lw cycle %0d: controls %h, required %h", cyc, got, exp);
            else passes++;
        end
        @(negedge clk); #1;
        exp = masked(expect_ctl(M_LW, 3'b010, 1'b0, ZF, SF, 1));
        got = observed();
        checks++;
        if (got !== exp) $display("[TB] FAIL reset_mid_instr: controls %h, required %h", got, exp);
        else passes++;
        @(posedge clk); #1 areset = 1'b0;
        run_instr(M_LW, 3'b010, 1'b0, -1, -1, "post_reset_lw");
    endtask

    task automatic test_mem();
        run_instr(M_LW, 3'b010, 1'b1, -1, -1, "lw");
        run_instr(M_SW, 3'b010, 1'b0, -1, -1, "sw");
    endtask

    task automatic test_alu();
        run_instr(M_R, 3'b000, 1'b1, -1, -1, "r_sub");
        run_instr(M_R, 3'b111, 1'b0, -1, -1, "r_and");
        run_instr(M_I, 3'b000, 1'b1, -1, -1, "addi_f7");
        run_instr(M_I, 3'b101, 1'b1, -1, -1, "srai");
    endtask

    task automatic test_branch();
        run_instr(M_B, 3'b000, 1'b0, 1, 0, "beq_zf1");
        run_instr(M_B, 3'b000, 1'b0, 0, 1, "beq_zf0");
        run_instr(M_B, 3'b001, 1'b0, 1, 0, "bne_zf1");
        run_instr(M_B, 3'b001, 1'b0, 0, 0, "bne_zf0");
        run_instr(M_B, 3'b100, 1'b0, 0, 1, "blt_sf1");
        run_instr(M_B, 3'b010, 1'b0, 1, 1, "b_f3_010");
    endtask

    task automatic test_jal_nop();
        run_instr(M_JAL, 3'b000, 1'b0, -1, -1, "jal");
        run_instr(7'b0000000, 3'b000, 1'b0, -1, -1, "nop_op0");
    endtask

    task automatic test_back_to_back();
        logic [6:0] o;
        logic [6:0] kinds [6];
        kinds = '{M_LW, M_SW, M_R, M_I, M_B, M_JAL};
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 6);
            if (r < 6) begin
                o = kinds[r];
            end else begin
                o = 7'($urandom_range(0, 127));
                if (latency(o) != 2) o = 7'b1111111;
            end
            run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_mem();
        test_alu();
        test_branch();
        test_jal_nop();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
